// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : Parametrised UART transmitter, one word per valid/ready handshake,
//            paced by an oversampled baud tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int c_TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (OVERSAMPLE < 2) begin : g_bad_oversample
            $error("uart_tx_frame: OVERSAMPLE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state,    w_state_next;
    logic [c_TICK_W-1:0]   r_tick_cnt, w_tick_next;
    logic [c_IDX_W-1:0]    r_idx,      w_idx_next;
    logic                  r_stop_cnt, w_stop_next;
    logic [DATA_BITS-1:0]  r_shift,    w_shift_next;
    logic                  r_parity,   w_parity_next;
    logic                  r_tx,       w_tx_next;
    logic                  r_busy,     w_busy_next;
    logic                  r_done,     w_done_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_idx      <= w_idx_next;
            r_stop_cnt <= w_stop_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // The line value for the next bit is decided at the bit boundary, so o_tx
    // is a pure register and never follows the inputs combinationally.
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick_cnt;
        w_idx_next    = r_idx;
        w_stop_next   = r_stop_cnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;

        if (r_state == S_IDLE) begin
            if (i_valid) begin
                w_shift_next  = i_data;
                w_parity_next = (PARITY == 2) ? ~^i_data : ^i_data;
                w_tx_next     = 1'b0;
                w_busy_next   = 1'b1;
                w_tick_next   = '0;
                w_idx_next    = '0;
                w_stop_next   = 1'b0;
                w_state_next  = S_START;
            end
        end else if (baud_tick) begin
            if (r_tick_cnt != c_TICK_LAST) begin
                w_tick_next = r_tick_cnt + 1'b1;
            end else begin
                w_tick_next = '0;
                case (r_state)
                    S_START: begin
                        w_state_next = S_DATA;
                        w_tx_next    = r_shift[0];
                    end
                    S_DATA: begin
                        if (r_idx == c_IDX_LAST) begin
                            if (PARITY != 0) begin
                                w_state_next = S_PARITY;
                                w_tx_next    = r_parity;
                            end else begin
                                w_state_next = S_STOP;
                                w_tx_next    = 1'b1;
                            end
                        end else begin
                            // Shifting keeps the current bit at index 0 of the hold register.
                            w_idx_next   = r_idx + 1'b1;
                            w_shift_next = r_shift >> 1;
                            w_tx_next    = r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end
                    S_STOP: begin
                        if ((STOP_BITS == 2) && !r_stop_cnt) begin
                            w_stop_next = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                            w_tx_next    = 1'b1;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                        w_busy_next  = 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ready   = (r_state == S_IDLE);
    assign o_tx      = r_tx;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Self-checking bench for uart_tx_frame over several configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    localparam int c_NDUT = 5;
    localparam int c_BITS [c_NDUT] = '{8, 8, 8, 5, 9};
    localparam int c_PAR  [c_NDUT] = '{0, 1, 2, 0, 2};
    localparam int c_STOP [c_NDUT] = '{1, 1, 1, 2, 2};
    localparam int c_OS   [c_NDUT] = '{8, 8, 8, 8, 3};

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       valid_a [c_NDUT];
    logic [8:0] data_a  [c_NDUT];
    logic       ready_a [c_NDUT];
    logic       tx_a    [c_NDUT];
    logic       busy_a  [c_NDUT];
    logic       done_a  [c_NDUT];

    int n_cmp;
    int n_bad;
    int sel;
    int tick_period;
    int tcnt;

    genvar g;
    generate
        for (g = 0; g < c_NDUT; g++) begin : g_dut
            uart_tx_frame #(
                .DATA_BITS (c_BITS[g]),
                .PARITY    (c_PAR[g]),
                .STOP_BITS (c_STOP[g]),
                .OVERSAMPLE(c_OS[g])
            ) u_dut (
                .clk      (clk),
                .rst      (rst),
                .baud_tick(baud_tick),
                .i_valid  (valid_a[g]),
                .i_data   (data_a[g][c_BITS[g]-1:0]),
                .o_ready  (ready_a[g]),
                .o_tx     (tx_a[g]),
                .o_tx_busy(busy_a[g]),
                .o_tx_done(done_a[g])
            );
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick pulses change on the falling edge, one clk wide, every tick_period clks.
    initial begin
        baud_tick = 1'b0;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt++;
            if (tcnt >= tick_period) tcnt = 0;
            baud_tick = (tcnt == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop ones.
    function automatic void model(input int s, input logic [8:0] d,
                                  output logic [15:0] eb, output int len);
        logic p;
        eb  = '0;
        len = 0;
        eb[len] = 1'b0; len++;
        for (int i = 0; i < c_BITS[s]; i++) begin
            eb[len] = d[i]; len++;
        end
        if (c_PAR[s] != 0) begin
            p = 1'b0;
            for (int i = 0; i < c_BITS[s]; i++) p = p ^ d[i];
            if (c_PAR[s] == 2) p = ~p;
            eb[len] = p; len++;
        end
        for (int i = 0; i < c_STOP[s]; i++) begin
            eb[len] = 1'b1; len++;
        end
    endfunction

    // Called at clk+1 right after the accept edge; returns at clk+1 of the done edge.
    task automatic check_frame(input string nm, input logic [15:0] eb, input int len,
                               input bit noise);
        int   b, tk, cyc, limit, bad_cyc, os;
        logic ctl_bad, ticked;
        os = c_OS[sel];
        b = 0; tk = 0; cyc = 0; bad_cyc = 0; ctl_bad = 1'b0;
        limit = len * os * tick_period + 50;
        while (b < len && cyc < limit) begin
            if (tx_a[sel] !== eb[b]) bad_cyc++;
            if (busy_a[sel] !== 1'b1 || ready_a[sel] !== 1'b0 || done_a[sel] !== 1'b0)
                ctl_bad = 1'b1;
            if (noise) begin
                valid_a[sel] = 1'($urandom);
                data_a[sel]  = 9'($urandom);
            end
            @(posedge clk);
            ticked = baud_tick;
            #1;
            cyc++;
            if (ticked) begin
                tk++;
                if (tk == os) begin
                    check($sformatf("%s_bit%0d_badcycles", nm, b), bad_cyc, 0);
                    b++;
                    tk = 0;
                    bad_cyc = 0;
                end
            end
        end
        check($sformatf("%s_bits_seen", nm), b, len);
        check($sformatf("%s_busy_ready_in_frame", nm), ctl_bad, 0);
        check($sformatf("%s_end_tx_busy_done_ready", nm),
              {tx_a[sel], busy_a[sel], done_a[sel], ready_a[sel]}, 4'b1011);
    endtask

    task automatic send(input int s, input logic [8:0] d, input logic [15:0] eb,
                        input int len, input string nm, input bit noise);
        sel = s;
        @(negedge clk);
        valid_a[s] = 1'b1;
        data_a[s]  = d;
        check({nm, "_ready_before"}, ready_a[s], 1'b1);
        @(posedge clk);
        #1;
        valid_a[s] = 1'b0;
        check_frame(nm, eb, len, noise);
        valid_a[s] = 1'b0;
        @(posedge clk);
        #1;
        check({nm, "_idle_after"}, {tx_a[s], busy_a[s], done_a[s], ready_a[s]}, 4'b1001);
    endtask

    typedef struct {
        int          sel;
        logic [8:0]  data;
        logic [15:0] exp_bits;
        int          len;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] eb;
    int          len;
    int          tk;
    int          cyc;
    logic        saw_done;
    logic [8:0]  d;
    int          s;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sel = 0;
        tick_period = 4;
        rst = 1'b1;
        for (int i = 0; i < c_NDUT; i++) begin
            valid_a[i] = 1'b0;
            data_a[i]  = '0;
        end

        vecs[0] = '{0, 9'h055, 16'h02AA, 10};
        vecs[1] = '{1, 9'h007, 16'h060E, 11};
        vecs[2] = '{2, 9'h007, 16'h040E, 11};
        vecs[3] = '{1, 9'h000, 16'h0400, 11};
        vecs[4] = '{3, 9'h01A, 16'h00F4, 8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < c_NDUT; i++)
            check($sformatf("reset_dut%0d", i),
                  {tx_a[i], busy_a[i], done_a[i], ready_a[i]}, 4'b1001);

        for (int i = 0; i < 5; i++)
            send(vecs[i].sel, vecs[i].data, vecs[i].exp_bits, vecs[i].len,
                 $sformatf("vec%0d", i), 1'b0);

        // FIFO holding 0xA3 then 0x3C, valid held high across both frames
        sel = 0;
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h0A3;
        @(posedge clk);
        #1;
        data_a[0] = 9'h03C;
        model(0, 9'h0A3, eb, len);
        check_frame("fifo_a3", eb, len, 1'b0);
        @(posedge clk);
        #1;
        valid_a[0] = 1'b0;
        model(0, 9'h03C, eb, len);
        check_frame("fifo_3c", eb, len, 1'b0);
        @(posedge clk);
        #1;
        check("fifo_idle_after", {tx_a[0], busy_a[0], done_a[0], ready_a[0]}, 4'b1001);

        // Reset in the middle of data bit 3 of 0xFF
        sel = 0;
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h0FF;
        @(posedge clk);
        #1;
        valid_a[0] = 1'b0;
        tk = 0;
        cyc = 0;
        while (tk < 36 && cyc < 1000) begin
            @(posedge clk);
            if (baud_tick) tk++;
            #1;
            cyc++;
        end
        check("rst_reached_bit3", tk, 36);
        check("rst_busy_before", busy_a[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_values", {tx_a[0], busy_a[0], done_a[0], ready_a[0]}, 4'b1001);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a[0] !== 1'b0) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_done", saw_done, 1'b0);
        send(0, 9'h081, 16'h0302, 10, "after_rst_81", 1'b0);

        // Inputs toggled randomly during the frame must not disturb it
        model(0, 9'h0C4, eb, len);
        send(0, 9'h0C4, eb, len, "noise_c4", 1'b1);

        for (int k = 0; k < 12; k++) begin
            s = $urandom_range(0, c_NDUT - 1);
            d = 9'($urandom);
            tick_period = $urandom_range(1, 5);
            model(s, d, eb, len);
            send(s, d, eb, len, $sformatf("rand%0d_dut%0d", k, s), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: successor to the fixed 8N1 transmitter in the UART/FIFO controller path. It serialises one word per valid/ready handshake, with compile-time data width, parity mode, stop-bit count and oversampling ratio. It is driven by the shared oversampled `baud_tick` from the baud generator. Its upstream is normally the TX FIFO pop side: `o_ready` acts as pop and `!empty` acts as `i_valid`.

## Interface
- `DATA_BITS`, default 8: payload bits per frame; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `OVERSAMPLE`, default 8: `baud_tick` pulses per bit period; legal range ≥2.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `baud_tick`, in, 1: one-`clk`-wide pulse at BAUD*OVERSAMPLE rate.
- `i_valid`, in, 1: upstream word available.
- `i_data`, in, `DATA_BITS`: word to send, LSB first.
- `o_ready`, out, 1: block can accept a word this cycle.
- `o_tx`, out, 1: serial line, registered, idle high.
- `o_tx_busy`, out, 1: frame in progress.
- `o_tx_done`, out, 1: one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Registers: 3-bit state, tick counter `tick_cnt` of width `$clog2(OVERSAMPLE)`, bit index of width `$clog2(DATA_BITS)`, stop counter of 1 bit, shift/hold register of `DATA_BITS`, registered parity bit.
- Accept: `i_valid && o_ready` in IDLE. `o_ready` = (state == IDLE), so it is 1 whenever idle.
  - On the accept edge: latch `i_data`, compute parity (even = ^data, odd = ~^data), set `tx`=0, set busy=1, clear counters, go to START.
- Bit period: while in START/DATA/PARITY/STOP, each `baud_tick` increments `tick_cnt`.
  - A `baud_tick` with `tick_cnt == OVERSAMPLE-1` ends the bit: `tick_cnt` goes to 0 and the state/index advances.
  - Cycles without a tick change nothing.
- START -> DATA at the end of the start bit; `o_tx` = data[0].
- DATA: `o_tx` = data[idx]. At bit end, `idx == DATA_BITS-1` goes to PARITY if `PARITY != 0`, otherwise to STOP. Otherwise `idx` increments.
- PARITY: `o_tx` = parity bit. At bit end -> STOP.
- STOP: `o_tx` = 1.
  - At the end of the final stop bit (the second one if `STOP_BITS == 2`): go to IDLE, busy=0, done=1 for one cycle.
- `o_tx` changes only on state/bit transitions. It is never combinationally derived from inputs.
- `i_data` is ignored outside the accept cycle. Changes mid-frame do not affect the line.
- `i_valid` high during a frame is held off: `o_ready` = 0, nothing is latched, nothing is dropped.
- Illegal parameters cause an elaboration-time `$error` (generate check).

## Timing
- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0, `o_ready`=1, state IDLE, all counters 0.
- Reset asserted mid-frame returns immediately to these values. The partial frame is abandoned, and the line goes high asynchronously.
- Accept-to-line latency: `o_tx` falls on the same edge that accepts the word (1 `clk` after `i_valid` is sampled).
- Each bit lasts exactly `OVERSAMPLE` `baud_tick` events.
  - The first bit's wall-clock length is shortened by the phase of `baud_tick` relative to accept: at most 1 tick period.
- Frame length in ticks = OVERSAMPLE*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS).
  - Example: 8N1 with OVERSAMPLE=8 is 80 ticks.
- `o_tx_done` and the busy fall occur on the same edge as re-entry to IDLE.
  - `o_ready` = 1 in that same cycle, so the next frame can be accepted 1 `clk` after done.
  - Minimum idle gap is one `clk`. Back-to-back frames from a FIFO therefore carry no extra stop time.
- A `baud_tick` on the accept cycle is not counted toward the start bit.
- `tick_cnt` wraps from OVERSAMPLE-1 to 0 only at a bit end. There is no other wrap.

## Test plan
- Defaults (8N1, OVERSAMPLE=8, tick every 4 clk), send 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop). Each bit is 8 ticks. Done pulses once after 80 ticks. Busy is high throughout.
- PARITY=1, send 0x07 -> parity bit 1. PARITY=2, send 0x07 -> parity bit 0. PARITY=1, send 0x00 -> parity bit 0. Frame is 88 ticks.
- DATA_BITS=5, STOP_BITS=2, send 5'h1A -> 0,0,1,0,1,1,1,1. Line stays high for 16 ticks before done.
- FIFO model holding 0xA3 then 0x3C with `i_valid` held high -> second accept occurs the cycle after done. Line shows no extra idle beyond one clk. Both bytes decode correctly. `o_ready` stays 0 for the whole of each frame.
- Assert `rst` during DATA bit 3 of 0xFF -> `o_tx`=1 and busy=0 immediately, no done pulse. After release, send 0x81 -> clean full frame.
- Toggle `i_data` and `i_valid` randomly during a frame of 0xC4 -> transmitted bits match 0xC4 exactly.
